// File: rtl/photon_histo_acq.sv
// Photon-timing accumulator: qualifies LVDS phase-bin photons, drives masked triggers,
// and keeps saturating per-bin and inter-photon-interval histograms behind an addressed read port.
module photon_histo_acq #(
  parameter int NBINS    = 8,
  parameter int IPI_BINS = 64,
  parameter int CNT_W    = 32,
  parameter int IPI_W    = 8,
  parameter int AW       = $clog2((NBINS > IPI_BINS) ? NBINS : IPI_BINS)
) (
  input  logic              clkin,
  input  logic              nrst,
  input  logic [NBINS-1:0]  lvds_rx,
  input  logic              pmt_in,
  input  logic              passthrough,
  input  logic              vetopmtlast,
  input  logic [NBINS-1:0]  mask1,
  input  logic [NBINS-1:0]  mask2,
  input  logic [IPI_W-1:0]  veto_cycles,
  input  logic [31:0]       acq_cycles,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              rd_en,
  input  logic              rd_sel,
  input  logic [AW-1:0]     rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              out1,
  output logic              out2,
  output logic              anyphot,
  output logic              inveto,
  output logic              collision,
  output logic              running,
  output logic              done,
  output logic              busy
);

  localparam int DEPTH  = (NBINS > IPI_BINS) ? NBINS : IPI_BINS;
  localparam int NB_AW  = $clog2(NBINS);
  localparam int IPI_AW = $clog2(IPI_BINS);
  localparam int AW1    = AW + 1;
  localparam logic [AW:0]       NB_LIM      = AW1'(NBINS);
  localparam logic [AW:0]       IPI_LIM     = AW1'(IPI_BINS);
  localparam logic [IPI_W-1:0]  IPI_CNT_LIM = IPI_W'(IPI_BINS);
  localparam logic [AW-1:0]     K_LAST      = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [IPI_W-1:0]  IPI_CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_CLEAR} state_t;

  state_t             state_q, state_d;
  logic [31:0]        win_q, win_d;
  logic [AW-1:0]      clr_k_q, clr_k_d;
  logic [IPI_W-1:0]   ipi_cnt_q, ipi_cnt_d;
  logic               last0_q;

  logic [CNT_W-1:0]   histo_q [NBINS];
  logic [CNT_W-1:0]   histo_d [NBINS];
  logic [CNT_W-1:0]   ipi_hist_q [IPI_BINS];

  logic [NBINS-1:0]   supp;
  logic [NBINS-1:0]   phot;
  logic               in_veto;
  logic               any_phot;

  logic               out1_q, out2_q, anyphot_q, inveto_q, collision_q;
  logic [CNT_W-1:0]   rd_data_q, rd_word;
  logic               rd_valid_q;

  // Next-bin suppression: a photon edge smeared into the following bin (or the next clock) is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NBINS - 1; gi++) begin : g_supp
      assign supp[gi] = lvds_rx[gi] & ~(vetopmtlast & lvds_rx[gi+1]);
    end
  endgenerate
  assign supp[NBINS-1] = lvds_rx[NBINS-1] & ~(vetopmtlast & last0_q);

  assign in_veto  = (ipi_cnt_q < veto_cycles);
  assign phot     = (in_veto || passthrough) ? '0 : supp;
  assign any_phot = |phot;

  always_comb begin
    ipi_cnt_d = ipi_cnt_q;
    if (!passthrough) begin
      if (any_phot)                      ipi_cnt_d = '0;
      else if (ipi_cnt_q != IPI_CNT_MAX) ipi_cnt_d = ipi_cnt_q + IPI_W'(1);
    end
  end

  generate
    for (gi = 0; gi < NBINS; gi++) begin : g_bin
      assign histo_d[gi] =
        (state_q == S_CLEAR && clr_k_q == AW'(gi))              ? '0 :
        (state_q == S_RUN && phot[gi] && histo_q[gi] != CNT_MAX) ? histo_q[gi] + CNT_W'(1) :
                                                                  histo_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    clr_k_d = clr_k_q;
    if (clear) begin
      state_d = S_CLEAR;
      clr_k_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && !stop) begin
            state_d = S_RUN;
            win_d   = acq_cycles;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_DONE;
          end else if (win_q != '0) begin
            // A zero load means an unbounded window; otherwise the last counted cycle still accumulates.
            win_d = win_q - 32'd1;
            if (win_q == 32'd1) state_d = S_DONE;
          end
        end
        S_CLEAR: begin
          if (clr_k_q == K_LAST) state_d = S_IDLE;
          else                   clr_k_d = clr_k_q + AW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_sel) begin
      if ({1'b0, rd_addr} < IPI_LIM) rd_word = ipi_hist_q[rd_addr[IPI_AW-1:0]];
    end else begin
      if ({1'b0, rd_addr} < NB_LIM)  rd_word = histo_q[rd_addr[NB_AW-1:0]];
    end
  end

  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      clr_k_q     <= '0;
      ipi_cnt_q   <= '1;
      last0_q     <= 1'b0;
      out1_q      <= 1'b0;
      out2_q      <= 1'b0;
      anyphot_q   <= 1'b0;
      inveto_q    <= 1'b0;
      collision_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      for (int i = 0; i < NBINS; i++) histo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      clr_k_q     <= clr_k_d;
      ipi_cnt_q   <= ipi_cnt_d;
      last0_q     <= lvds_rx[0];
      out1_q      <= passthrough ? pmt_in   : |(phot & mask1);
      out2_q      <= passthrough ? |lvds_rx : |(phot & mask2);
      anyphot_q   <= any_phot;
      inveto_q    <= in_veto;
      collision_q <= in_veto & (|lvds_rx);
      rd_valid_q  <= rd_en;
      if (rd_en) rd_data_q <= rd_word;
      for (int i = 0; i < NBINS; i++) histo_q[i] <= histo_d[i];
    end
  end

  // One write port: sweep-clear in CLEAR, saturating increment of the interval bin in RUN.
  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < IPI_BINS; i++) ipi_hist_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      if ({1'b0, clr_k_q} < IPI_LIM) ipi_hist_q[clr_k_q[IPI_AW-1:0]] <= '0;
    end else if (state_q == S_RUN && any_phot && ipi_cnt_q < IPI_CNT_LIM) begin
      if (ipi_hist_q[ipi_cnt_q[IPI_AW-1:0]] != CNT_MAX)
        ipi_hist_q[ipi_cnt_q[IPI_AW-1:0]] <= ipi_hist_q[ipi_cnt_q[IPI_AW-1:0]] + CNT_W'(1);
    end
  end

  assign out1      = out1_q;
  assign out2      = out2_q;
  assign anyphot   = anyphot_q;
  assign inveto    = inveto_q;
  assign collision = collision_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign running   = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_photon_histo_acq.sv
// Directed bench for photon_histo_acq; a CNT_W=4 copy shares the stimulus for saturation checks.
module tb_photon_histo_acq;

  localparam int NBINS = 8;
  localparam int AW    = 6;

  logic              clkin = 1'b0;
  logic              nrst;
  logic [NBINS-1:0]  lvds_rx, mask1, mask2;
  logic              pmt_in, passthrough, vetopmtlast;
  logic [7:0]        veto_cycles;
  logic [31:0]       acq_cycles;
  logic              start, stop, clear, rd_en, rd_sel;
  logic [AW-1:0]     rd_addr;

  logic [31:0]       rd_data;
  logic              rd_valid, out1, out2, anyphot, inveto, collision, running, done, busy;
  logic [3:0]        rd_data_s;
  logic              rd_valid_s, out1_s, out2_s, anyphot_s, inveto_s, collision_s;
  logic              running_s, done_s, busy_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clkin = ~clkin;

  photon_histo_acq dut (
    .clkin(clkin), .nrst(nrst), .lvds_rx(lvds_rx), .pmt_in(pmt_in),
    .passthrough(passthrough), .vetopmtlast(vetopmtlast), .mask1(mask1), .mask2(mask2),
    .veto_cycles(veto_cycles), .acq_cycles(acq_cycles), .start(start), .stop(stop),
    .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .out1(out1), .out2(out2),
    .anyphot(anyphot), .inveto(inveto), .collision(collision),
    .running(running), .done(done), .busy(busy)
  );

  photon_histo_acq #(.CNT_W(4)) dut_sat (
    .clkin(clkin), .nrst(nrst), .lvds_rx(lvds_rx), .pmt_in(pmt_in),
    .passthrough(passthrough), .vetopmtlast(vetopmtlast), .mask1(mask1), .mask2(mask2),
    .veto_cycles(veto_cycles), .acq_cycles(acq_cycles), .start(start), .stop(stop),
    .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s), .out1(out1_s), .out2(out2_s),
    .anyphot(anyphot_s), .inveto(inveto_s), .collision(collision_s),
    .running(running_s), .done(done_s), .busy(busy_s)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clkin);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_read(input logic sel, input int addr);
    rd_en   = 1'b1;
    rd_sel  = sel;
    rd_addr = addr[AW-1:0];
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic apply_reset;
    lvds_rx = '0; mask1 = '0; mask2 = '0; pmt_in = 1'b0; passthrough = 1'b0;
    vetopmtlast = 1'b0; veto_cycles = '0; acq_cycles = '0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_sel = 1'b0; rd_addr = '0;
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    apply_reset();
    check_val("rst_out1", out1, 0);
    check_val("rst_out2", out2, 0);
    check_val("rst_anyphot", anyphot, 0);
    check_val("rst_inveto", inveto, 0);
    check_val("rst_collision", collision, 0);
    check_val("rst_running", running, 0);
    check_val("rst_done", done, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_rd_valid", rd_valid, 0);
    check_val("rst_rd_data", rd_data, 0);

    // First photon after reset: triggers, but lands in no IPI bin
    mask1 = 8'h01; mask2 = 8'h02;
    pulse_start();
    check_val("fp_running", running, 1);
    lvds_rx = 8'h01;
    tick();
    lvds_rx = 8'h00;
    check_val("fp_out1", out1, 1);
    check_val("fp_out2", out2, 0);
    check_val("fp_anyphot", anyphot, 1);
    check_val("fp_inveto", inveto, 0);
    tick();
    check_val("fp_out1_low", out1, 0);
    for (int a = 0; a < 64; a++) begin
      do_read(1'b1, a);
      check_val($sformatf("fp_ipi%0d", a), rd_data, 0);
    end
    do_read(1'b0, 0);
    check_val("fp_rd_valid", rd_valid, 1);
    check_val("fp_histo0", rd_data, 1);

    // Next-bin suppression
    apply_reset();
    vetopmtlast = 1'b1;
    pulse_start();
    lvds_rx = 8'h06; tick();
    lvds_rx = 8'h00; tick();
    lvds_rx = 8'h01; tick();
    lvds_rx = 8'h80; tick();
    lvds_rx = 8'h00; tick();
    do_read(1'b0, 2); check_val("sup_histo2", rd_data, 1);
    do_read(1'b0, 1); check_val("sup_histo1", rd_data, 0);
    do_read(1'b0, 0); check_val("sup_histo0", rd_data, 1);
    do_read(1'b0, 7); check_val("sup_histo7_vetoed", rd_data, 0);
    lvds_rx = 8'h80; tick();
    lvds_rx = 8'h00; tick();
    do_read(1'b0, 7); check_val("sup_histo7_kept", rd_data, 1);

    // Holdoff and IPI binning
    apply_reset();
    veto_cycles = 8'd3;
    pulse_start();
    for (int c = 0; c < 76; c++) begin
      lvds_rx = (c == 0 || c == 2 || c == 5 || c == 70) ? 8'h01 : 8'h00;
      tick();
      if (c == 0) check_val("ho_anyphot_c0", anyphot, 1);
      if (c == 2) begin
        check_val("ho_anyphot_c2", anyphot, 0);
        check_val("ho_inveto_c2", inveto, 1);
        check_val("ho_collision_c2", collision, 1);
      end
      if (c == 5) begin
        check_val("ho_anyphot_c5", anyphot, 1);
        check_val("ho_collision_c5", collision, 0);
      end
      if (c == 70) check_val("ho_anyphot_c70", anyphot, 1);
    end
    lvds_rx = 8'h00;
    do_read(1'b1, 4);  check_val("ho_ipi4", rd_data, 1);
    do_read(1'b1, 1);  check_val("ho_ipi1", rd_data, 0);
    do_read(1'b1, 63); check_val("ho_ipi63", rd_data, 0);
    do_read(1'b0, 0);  check_val("ho_histo0", rd_data, 3);

    // Acquisition window, then resume unbounded
    apply_reset();
    acq_cycles = 32'd10;
    lvds_rx = 8'h01;
    pulse_start();
    check_val("win_running", running, 1);
    repeat (14) tick();
    check_val("win_done", done, 1);
    check_val("win_not_running", running, 0);
    do_read(1'b0, 0); check_val("win_histo0_10", rd_data, 10);
    acq_cycles = 32'd0;
    pulse_start();
    repeat (4) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check_val("win_done2", done, 1);
    do_read(1'b0, 0); check_val("win_histo0_15", rd_data, 15);
    lvds_rx = 8'h00;

    // Saturation (second instance has 4-bit counters) and read-port boundaries
    apply_reset();
    pulse_start();
    lvds_rx = 8'h08;
    repeat (20) tick();
    lvds_rx = 8'h00;
    do_read(1'b0, 11);
    check_val("rd_oob_bin", rd_data, 0);
    check_val("rd_oob_bin_sat", rd_data_s, 0);
    do_read(1'b0, 3);
    check_val("sat_histo3_wide", rd_data, 20);
    check_val("sat_histo3_narrow", rd_data_s, 15);
    tick();
    check_val("rd_valid_pulse", rd_valid, 0);
    check_val("rd_data_hold", rd_data, 20);
    do_read(1'b1, 0);
    check_val("sat_ipi0_wide", rd_data, 19);
    check_val("sat_ipi0_narrow", rd_data_s, 15);

    // Clear mid-run: one full sweep, then everything reads zero
    lvds_rx = 8'h08;
    clear = 1'b1; tick(); clear = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      n++;
      tick();
    end
    lvds_rx = 8'h00;
    check_val("clr_busy_cycles", n, 64);
    check_val("clr_idle_running", running, 0);
    check_val("clr_idle_done", done, 0);
    for (int a = 0; a < 64; a++) begin
      do_read(1'b0, a); check_val($sformatf("clr_histo%0d", a), rd_data, 0);
      do_read(1'b1, a); check_val($sformatf("clr_ipi%0d", a), rd_data, 0);
    end

    // Clear re-issued at k=30 restarts the sweep
    pulse_start();
    lvds_rx = 8'h08;
    repeat (3) tick();
    lvds_rx = 8'h00;
    clear = 1'b1; tick(); clear = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      n++;
      if (n == 31) clear = 1'b1;
      tick();
      clear = 1'b0;
    end
    check_val("clr2_busy_cycles", n, 95);
    do_read(1'b0, 3); check_val("clr2_histo3", rd_data, 0);

    // Passthrough: raw routing to the outputs, no accounting
    apply_reset();
    pulse_start();
    mask1 = 8'hFF; mask2 = 8'hFF;
    passthrough = 1'b1;
    pmt_in = 1'b1; lvds_rx = 8'h00; tick();
    check_val("pt_out1_pmt", out1, 1);
    check_val("pt_out2_idle", out2, 0);
    pmt_in = 1'b0; lvds_rx = 8'h10; tick();
    check_val("pt_out1_low", out1, 0);
    check_val("pt_out2_or", out2, 1);
    check_val("pt_anyphot", anyphot, 0);
    passthrough = 1'b0; lvds_rx = 8'h00; tick();
    do_read(1'b0, 4); check_val("pt_histo4", rd_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
